// File: rtl/aes_tx_pkg.sv
// Shared types and constants for the AES result hex printer.
package aes_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEX  = 2'd1,
    CR   = 2'd2,
    LF   = 2'd3
  } hex_tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/hex_ascii.sv
// Converts one nibble to its upper-case ASCII hex digit.
module hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/aes_hex_tx.sv
// Prints a block as ASCII hex, MS nibble first, with optional CR LF trailer,
// over a valid/ready character stream.
module aes_hex_tx
  import aes_tx_pkg::*;
#(
  parameter int unsigned NIBBLES  = 32,
  parameter bit          ADD_CRLF = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NIBBLES-1:0] blk_in,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic [7:0]           char_out,
  output logic                 char_valid,
  input  logic                 char_ready,
  output logic                 busy
);

  localparam int unsigned BLK_W = 4 * NIBBLES;
  localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  hex_tx_state_t    state_q, state_d;
  logic [BLK_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hex_char;

  hex_ascii u_hex_ascii (
    .nibble (shreg_q[BLK_W-1 -: 4]),
    .ascii  (hex_char)
  );

  // Next-state: a character advances only on its own handshake.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (blk_valid) begin
          shreg_d = blk_in;
          cnt_d   = '0;
          state_d = HEX;
        end
      end
      HEX: begin
        if (char_ready) begin
          shreg_d = shreg_q << 4;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ADD_CRLF ? CR : IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CR: begin
        if (char_ready) state_d = LF;
      end
      LF: begin
        if (char_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only; ready is held low during reset.
  always_comb begin
    char_out   = 8'h00;
    char_valid = 1'b0;
    unique case (state_q)
      HEX: begin
        char_out   = hex_char;
        char_valid = 1'b1;
      end
      CR: begin
        char_out   = ASCII_CR;
        char_valid = 1'b1;
      end
      LF: begin
        char_out   = ASCII_LF;
        char_valid = 1'b1;
      end
      default: begin
        char_out   = 8'h00;
        char_valid = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign blk_ready = (state_q == IDLE) && !rst;

endmodule

// File: tb/tb_aes_hex_tx.sv
// Scoreboard bench for aes_hex_tx: CRLF instance plus a no-CRLF instance.
module tb_aes_hex_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] blk_in;
  logic         blk_valid, blk_ready;
  logic [7:0]   char_out;
  logic         char_valid, char_ready, busy;

  logic [127:0] blk_in1;
  logic         blk_valid1, blk_ready1;
  logic [7:0]   char_out1;
  logic         char_valid1, char_ready1, busy1;

  always #5 clk = ~clk;

  aes_hex_tx #(.NIBBLES(32), .ADD_CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .blk_in(blk_in), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy)
  );

  aes_hex_tx #(.NIBBLES(32), .ADD_CRLF(1'b0)) dut1 (
    .clk(clk), .rst(rst), .blk_in(blk_in1), .blk_valid(blk_valid1),
    .blk_ready(blk_ready1), .char_out(char_out1), .char_valid(char_valid1),
    .char_ready(char_ready1), .busy(busy1)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  int         acc_cnt = 0;
  int         n_acc = 0;
  int         n_acc1 = 0;
  bit         rnd_ready = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic void push_exp(input string s, input bit crlf);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  // Scoreboard monitor for the CRLF instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", 128'(char_valid), 128'(1'b1));
        chk("hold_char", 128'(char_out), 128'(prev_char));
      end
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_char: got %h expected none", char_out);
        end else begin
          chk("char", 128'(char_out), 128'(exp_q.pop_front()));
        end
        acc_cnt++;
      end
      if (blk_valid && blk_ready) n_acc++;
      prev_stall = char_valid && !char_ready;
      prev_char  = char_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Scoreboard monitor for the no-CRLF instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (char_valid1 && char_ready1) begin
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_char1: got %h expected none", char_out1);
        end else begin
          chk("char1", 128'(char_out1), 128'(exp1_q.pop_front()));
        end
      end
      if (blk_valid1 && blk_ready1) n_acc1++;
    end
  end

  always @(posedge clk) begin
    #1;
    char_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send0(input logic [127:0] b, input string s, input bit crlf);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    blk_in    = b;
    blk_valid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (blk_ready) begin
        got = 1'b1;
        push_exp(s, crlf);
      end
    end
    if (!got) chk("accept_timeout", 128'(1'b0), 128'(1'b1));
    @(posedge clk);
  endtask

  task automatic wait_done0(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("done_timeout", 128'(1'b0), 128'(1'b1));
  endtask

  task automatic wait_acc(input int target, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      if (acc_cnt >= target) done = 1'b1;
    end
    if (!done) chk("acc_timeout", 128'(1'b0), 128'(1'b1));
  endtask

  initial begin
    string s_zero, s_f, s_a5;
    int    nvalid, a0, n0;
    s_zero = "";
    s_f    = "";
    s_a5   = "";
    for (int i = 0; i < 32; i++) begin
      s_zero = {s_zero, "0"};
      s_f    = {s_f, "F"};
    end
    for (int i = 0; i < 16; i++) s_a5 = {s_a5, "A5"};

    rst = 1'b1; blk_in = '0; blk_valid = 1'b0; char_ready = 1'b1;
    blk_in1 = '0; blk_valid1 = 1'b0; char_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_ready", 128'(blk_ready), 128'(1'b0));
    chk("rst_char_valid", 128'(char_valid), 128'(1'b0));
    chk("rst_char_out", 128'(char_out), 128'(8'h00));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_char_valid1", 128'(char_valid1), 128'(1'b0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 128'(blk_ready), 128'(1'b1));

    // Single block at full rate: 34 consecutive characters, ready on cycle 35.
    send0(128'h0123456789ABCDEFFEDCBA9876543210, "0123456789ABCDEFFEDCBA9876543210", 1'b1);
    #1 blk_valid = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (char_valid) nvalid++;
    end
    chk("burst_len", 128'(nvalid), 128'(34));
    @(negedge clk);
    chk("ready_cycle35", 128'(blk_ready), 128'(1'b1));
    chk("idle_valid", 128'(char_valid), 128'(1'b0));
    chk("q_after_single", 128'(exp_q.size()), 128'(0));

    // Random backpressure.
    rnd_ready = 1'b1;
    send0(128'h0123456789ABCDEFFEDCBA9876543210, "0123456789ABCDEFFEDCBA9876543210", 1'b1);
    #1 blk_valid = 1'b0;
    wait_done0(400);
    rnd_ready = 1'b0;

    // Back-to-back blocks with valid held high.
    n0 = n_acc;
    send0(128'h0, s_zero, 1'b1);
    send0({128{1'b1}}, s_f, 1'b1);
    #1 blk_valid = 1'b0;
    wait_done0(200);
    chk("b2b_accepts", 128'(n_acc - n0), 128'(2));

    // Valid pulsed mid-print is ignored.
    n0 = n_acc;
    send0(128'h0123456789ABCDEFFEDCBA9876543210, "0123456789ABCDEFFEDCBA9876543210", 1'b1);
    #1 blk_valid = 1'b0;
    a0 = acc_cnt;
    wait_acc(a0 + 5, 100);
    #1 blk_in = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF; blk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_ready_low", 128'(blk_ready), 128'(1'b0));
    end
    @(posedge clk);
    #1 blk_valid = 1'b0;
    wait_done0(200);
    chk("ignored_accepts", 128'(n_acc - n0), 128'(1));

    // Reset after 10 characters, then a fresh block prints from its start.
    send0(128'h0123456789ABCDEFFEDCBA9876543210, "0123456789ABCDEFFEDCBA9876543210", 1'b1);
    #1 blk_valid = 1'b0;
    a0 = acc_cnt;
    wait_acc(a0 + 10, 100);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valid", 128'(char_valid), 128'(1'b0));
    chk("rst_mid_busy", 128'(busy), 128'(1'b0));
    chk("rst_mid_ready", 128'(blk_ready), 128'(1'b0));
    @(posedge clk);
    #1 rst = 1'b0;
    send0({16{8'hA5}}, s_a5, 1'b1);
    #1 blk_valid = 1'b0;
    wait_done0(200);

    // No-CRLF instance: 32 characters then idle, period 33.
    @(posedge clk);
    #1 blk_in1 = 128'h00112233445566778899AABBCCDDEEFF; blk_valid1 = 1'b1;
    @(negedge clk);
    chk("nocrlf_ready", 128'(blk_ready1), 128'(1'b1));
    begin
      string s1;
      s1 = "00112233445566778899AABBCCDDEEFF";
      for (int i = 0; i < s1.len(); i++) exp1_q.push_back(8'(s1[i]));
    end
    @(posedge clk);
    #1 blk_valid1 = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (char_valid1) nvalid++;
    end
    chk("nocrlf_len", 128'(nvalid), 128'(32));
    @(negedge clk);
    chk("nocrlf_idle_valid", 128'(char_valid1), 128'(1'b0));
    chk("nocrlf_ready33", 128'(blk_ready1), 128'(1'b1));
    chk("nocrlf_accepts", 128'(n_acc1), 128'(1));

    repeat (3) @(negedge clk);
    chk("q_empty", 128'(exp_q.size()), 128'(0));
    chk("q1_empty", 128'(exp1_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
